mem_port_arbiter: RTL

Sequential arbiter that shares one single-ported 32-bit instruction/data memory between the fetch stage (read-only) and the memory stage (read/write) of the pipelined MIPS core. It latches a request, drives the memory port for a configurable number of cycles, returns registered read data with a one-cycle acknowledge, and alternates grants round-robin under contention. Unaligned word addresses are rejected without touching memory.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported 32-bit memory between the fetch stage
//             (read-only) and the memory stage (read/write). A request is
//             latched, the memory port is driven for WAIT_STATES+1 cycles,
//             read data is registered and a one-cycle ack is returned.
//             Contention is resolved round-robin; unaligned word addresses
//             are rejected with an error pulse and no memory cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err_unaligned
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic       c_GRANT_IF = 1'b0;
  localparam logic       c_GRANT_DM = 1'b1;
  localparam logic [2:0] c_WAIT     = 3'(WAIT_STATES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic        r_last_grant;
  logic        r_grant;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic        w_any_req;
  logic        w_dm_wins;
  logic [31:0] w_sel_addr;
  logic        w_sel_unaligned;
  logic        w_last_cycle;

  // Data port wins when it is the only requester, or when both request and
  // fetch was the most recent grantee.
  assign w_any_req       = if_req | dm_req;
  assign w_dm_wins       = dm_req & (~if_req | (r_last_grant == c_GRANT_IF));
  assign w_sel_addr      = w_dm_wins ? dm_addr : if_addr;
  assign w_sel_unaligned = |w_sel_addr[1:0];
  assign w_last_cycle    = (r_cnt == 3'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and all port outputs; everything is quiet outside ACCESS/RESP.
  always_comb begin
    w_state_nxt   = r_state;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    if_ack        = 1'b0;
    dm_ack        = 1'b0;
    err_unaligned = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_sel_unaligned ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (w_last_cycle) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if_ack        = (r_grant == c_GRANT_IF);
        dm_ack        = (r_grant == c_GRANT_DM);
        err_unaligned = r_err;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, wait counter and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 3'd0;
      r_last_grant <= c_GRANT_IF;
      r_grant      <= c_GRANT_IF;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_dm_wins;
            r_addr  <= w_sel_addr;
            r_we    <= w_dm_wins & dm_we;
            r_wdata <= w_dm_wins ? dm_wdata : 32'd0;
            r_err   <= w_sel_unaligned;
            r_cnt   <= c_WAIT;
          end
        end
        S_ACCESS: begin
          if (!w_last_cycle) begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          r_last_grant <= r_grant;
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Read data holding registers: captured on the last access cycle of a read,
  // cleared when the grantee's request is rejected as unaligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= 32'd0;
      r_dm_rdata <= 32'd0;
    end else if ((r_state == S_IDLE) && w_any_req && w_sel_unaligned) begin
      if (w_dm_wins) begin
        r_dm_rdata <= 32'd0;
      end else begin
        r_if_rdata <= 32'd0;
      end
    end else if ((r_state == S_ACCESS) && w_last_cycle && !r_we) begin
      if (r_grant == c_GRANT_DM) begin
        r_dm_rdata <= mem_rdata;
      end else begin
        r_if_rdata <= mem_rdata;
      end
    end
  end

  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule
`default_nettype wire
